// File: rtl/ysyx_24100006_pkg.sv
// Shared definitions for the fetch/decode boundary: data width, NOP encoding,
// the instruction/PC payload and the main-slot update selector.
package ysyx_24100006_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    MAIN_HOLD      = 2'd0,
    MAIN_FROM_IN   = 2'd1,
    MAIN_FROM_SKID = 2'd2,
    MAIN_CLEAR     = 2'd3
  } main_op_e;

endpackage

// File: rtl/ysyx_24100006_if_id_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID buffer.
// slave: the buffer itself; master: the IFU/IDU environment driving it.
interface ysyx_24100006_if_id_if;
  import ysyx_24100006_pkg::*;

  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instruction;
  logic [XLEN-1:0] if_pc;
  logic            flush;
  logic            id_out_valid;
  logic            id_out_ready;
  logic [XLEN-1:0] instruction;
  logic [XLEN-1:0] pc_D;

  modport slave (
    input  if_valid, if_instruction, if_pc, flush, id_out_ready,
    output if_ready, id_out_valid, instruction, pc_D
  );

  modport master (
    output if_valid, if_instruction, if_pc, flush, id_out_ready,
    input  if_ready, id_out_valid, instruction, pc_D
  );

endinterface

// File: rtl/ysyx_24100006_pipe_slot.sv
// One pipeline storage slot: valid bit plus instruction/PC registers.
// Data registers change only on reset, kill (instruction only) or load.
module ysyx_24100006_pipe_slot
  import ysyx_24100006_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_INST = NOP_INST,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kill,
  input  logic       load,
  input  logic       clear,
  input  fetch_pkt_t d,
  output logic       valid,
  output fetch_pkt_t q
);

  // Kill keeps the PC so decode still sees the last delivered address.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      q.inst <= RESET_INST;
      q.pc   <= RESET_PC;
    end else if (kill) begin
      valid  <= 1'b0;
      q.inst <= RESET_INST;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_24100006_if_id.sv
// IF/ID pipeline buffer between IFU and IDU with flush support.
// Define YSYX_24100006_IFID_SKID_EN for a two-slot skid buffer with fully
// registered if_ready; otherwise a single slot with pass-through ready.
module ysyx_24100006_if_id
  import ysyx_24100006_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_INST = NOP_INST,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  ysyx_24100006_if_id_if.slave  bus
);

  logic       main_v;
  fetch_pkt_t main_q;
  fetch_pkt_t main_d;
  fetch_pkt_t in_pkt;
  main_op_e   main_op;
  logic       accept_c;
  logic       xfer_c;

  assign in_pkt   = '{pc: bus.if_pc, inst: bus.if_instruction};
  assign accept_c = bus.if_valid & bus.if_ready;
  assign xfer_c   = bus.id_out_valid & bus.id_out_ready;

`ifdef YSYX_24100006_IFID_SKID_EN
  logic       skid_v;
  fetch_pkt_t skid_q;
  logic       skid_load;
  logic       skid_clear;

  // Skid full means main is full too, so ready depends only on skid_v.
  assign bus.if_ready = ~skid_v & ~reset;
  assign main_d       = (main_op == MAIN_FROM_SKID) ? skid_q : in_pkt;

  always_comb begin
    main_op    = MAIN_HOLD;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (!main_v) begin
      if (accept_c) main_op = MAIN_FROM_IN;
    end else if (xfer_c) begin
      if (skid_v) begin
        main_op    = MAIN_FROM_SKID;
        skid_clear = 1'b1;
      end else if (accept_c) begin
        main_op = MAIN_FROM_IN;
      end else begin
        main_op = MAIN_CLEAR;
      end
    end else if (accept_c) begin
      skid_load = 1'b1;
    end
  end

  ysyx_24100006_pipe_slot #(
    .RESET_INST (RESET_INST),
    .RESET_PC   (RESET_PC)
  ) u_skid_slot (
    .clk   (clk),
    .reset (reset),
    .kill  (bus.flush),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_pkt),
    .valid (skid_v),
    .q     (skid_q)
  );
`else
  // Single slot: accept whenever the slot is empty or draining this cycle.
  assign bus.if_ready = (~main_v | bus.id_out_ready) & ~reset;
  assign main_d       = in_pkt;

  always_comb begin
    main_op = MAIN_HOLD;
    if (accept_c) begin
      main_op = MAIN_FROM_IN;
    end else if (xfer_c) begin
      main_op = MAIN_CLEAR;
    end
  end
`endif

  ysyx_24100006_pipe_slot #(
    .RESET_INST (RESET_INST),
    .RESET_PC   (RESET_PC)
  ) u_main_slot (
    .clk   (clk),
    .reset (reset),
    .kill  (bus.flush),
    .load  ((main_op == MAIN_FROM_IN) | (main_op == MAIN_FROM_SKID)),
    .clear (main_op == MAIN_CLEAR),
    .d     (main_d),
    .valid (main_v),
    .q     (main_q)
  );

  // Valid is masked during reset so no transfer can complete in that cycle.
  assign bus.id_out_valid = main_v & ~reset;
  assign bus.instruction  = main_q.inst;
  assign bus.pc_D         = main_q.pc;

endmodule

// File: tb/tb_ysyx_24100006_if_id.sv
// Self-checking bench for ysyx_24100006_if_id: directed tables and sequences
// plus a randomized run, all watched by an in-order delivery scoreboard.
module tb_ysyx_24100006_if_id;
  import ysyx_24100006_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        erdy;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ysyx_24100006_if_id_if bus ();

  ysyx_24100006_if_id #(
    .RESET_INST (NOP_INST),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          errors = 0;
  int          checks = 0;
  int          delivered = 0;
  fetch_pkt_t  sb[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_inst = '0;
  logic [31:0] prev_pc = '0;
  logic [31:0] ifu_pc = '0;
`ifdef YSYX_24100006_IFID_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return {pc[19:0] ^ 20'h5a5a5, 12'h0b3};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string n, input logic ev, input logic [31:0] epc,
                         input logic [31:0] einst, input logic erdy);
    chk({n, "_valid"}, 32'(bus.id_out_valid), 32'(ev));
    chk({n, "_pc"}, bus.pc_D, epc);
    chk({n, "_inst"}, bus.instruction, einst);
    chk({n, "_if_ready"}, 32'(bus.if_ready), 32'(erdy));
  endtask

  task automatic drive(input logic v, input logic rdy, input logic fl, input logic rst);
    reset              = rst;
    bus.if_valid       = v;
    bus.if_pc          = ifu_pc;
    bus.if_instruction = mk_inst(ifu_pc);
    bus.id_out_ready   = rdy;
    bus.flush          = fl;
  endtask

  // Scoreboard and stall-stability monitor, evaluated mid-cycle.
  task automatic sample();
    fetch_pkt_t e;
    @(negedge clk);
    if (prev_stall) begin
      chk("stall_inst", bus.instruction, prev_inst);
      chk("stall_pc", bus.pc_D, prev_pc);
    end
    if (bus.id_out_valid && bus.id_out_ready) begin
      delivered++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: delivered pc %h, expected nothing", bus.pc_D);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", bus.pc_D, e.pc);
        chk("sb_inst", bus.instruction, e.inst);
      end
    end
    prev_stall = bus.id_out_valid & ~bus.id_out_ready & ~bus.flush & ~reset;
    prev_inst  = bus.instruction;
    prev_pc    = bus.pc_D;
    if (reset || bus.flush) begin
      sb.delete();
      if (bus.flush) ifu_pc = ifu_pc + 32'h0000_1000;
    end else if (bus.if_valid && bus.if_ready) begin
      e.pc   = bus.if_pc;
      e.inst = bus.if_instruction;
      sb.push_back(e);
      ifu_pc = ifu_pc + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic rdy, input logic fl, input logic rst);
    drive(v, rdy, fl, rst);
    sample();
    tick();
  endtask

  vec_t tbl[7];
  int   d0;

  initial begin
    tbl[0] = '{1'b1, 32'h8000_0000, 1'b1, 1'b0, RST_PC, NOP_INST, 1'b1};
    tbl[1] = '{1'b1, 32'h8000_0004, 1'b1, 1'b1, 32'h8000_0000, mk_inst(32'h8000_0000), 1'b1};
    tbl[2] = '{1'b1, 32'h8000_0008, 1'b1, 1'b1, 32'h8000_0004, mk_inst(32'h8000_0004), 1'b1};
    tbl[3] = '{1'b1, 32'h8000_000c, 1'b1, 1'b1, 32'h8000_0008, mk_inst(32'h8000_0008), 1'b1};
    tbl[4] = '{1'b1, 32'h8000_0010, 1'b1, 1'b1, 32'h8000_000c, mk_inst(32'h8000_000c), 1'b1};
    tbl[5] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h8000_0010, mk_inst(32'h8000_0010), 1'b1};
    tbl[6] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0010, mk_inst(32'h8000_0010), 1'b1};

    // Reset
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    sample();
    chk_out("reset", 1'b0, RST_PC, NOP_INST, 1'b0);
    tick();

    // Streaming at full rate
    d0 = delivered;
    for (int i = 0; i < 7; i++) begin
      ifu_pc = tbl[i].pc;
      drive(tbl[i].v, tbl[i].rdy, 1'b0, 1'b0);
      sample();
      chk_out($sformatf("stream%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].einst, tbl[i].erdy);
      tick();
    end
    chk("stream_count", 32'(delivered - d0), 32'd5);

    // Backpressure: 0x100 held, 0x104 into skid (skid build), 0x108 waits
    ifu_pc = 32'h100;
    drive(1'b1, 1'b0, 1'b0, 1'b0); sample();
    chk_out("bp0", 1'b0, 32'h8000_0010, mk_inst(32'h8000_0010), 1'b1); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0); sample();
    chk_out("bp1", 1'b1, 32'h100, mk_inst(32'h100), SKID); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0); sample();
    chk_out("bp2", 1'b1, 32'h100, mk_inst(32'h100), 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0); sample();
    chk_out("bp3", 1'b1, 32'h100, mk_inst(32'h100), 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0); sample();
    chk_out("bp4", 1'b1, 32'h100, mk_inst(32'h100), ~SKID); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0); sample();
    chk_out("bp5", 1'b1, 32'h104, mk_inst(32'h104), 1'b1); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0); sample();
    chk_out("bp6", 1'b1, 32'h108, mk_inst(32'h108), 1'b1); tick();
    step(1'b0, 1'b1, 1'b0, 1'b0);

    // Flush with slots full; redirect target accepted right after
    ifu_pc = 32'h104;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0); sample();
    chk_out("fl_cyc", 1'b1, 32'h104, mk_inst(32'h104), 1'b0); tick();
    ifu_pc = 32'h400;
    drive(1'b1, 1'b1, 1'b0, 1'b0); sample();
    chk_out("fl_after", 1'b0, 32'h104, NOP_INST, 1'b1); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0); sample();
    chk_out("fl_redir", 1'b1, 32'h400, mk_inst(32'h400), 1'b1); tick();
    step(1'b0, 1'b1, 1'b0, 1'b0);

    // Transfer and accept in the same cycle with main full
    ifu_pc = 32'h300;
    drive(1'b1, 1'b1, 1'b0, 1'b0); sample();
    chk("ta0_if_ready", 32'(bus.if_ready), 32'd1); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0); sample();
    chk_out("ta1", 1'b1, 32'h300, mk_inst(32'h300), 1'b1); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0); sample();
    chk_out("ta2", 1'b1, 32'h304, mk_inst(32'h304), 1'b1); tick();
    step(1'b0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a stall
    ifu_pc = 32'h500;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1); sample();
    chk("rs_valid", 32'(bus.id_out_valid), 32'd0);
    chk("rs_if_ready", 32'(bus.if_ready), 32'd0); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0); sample();
    chk_out("rs_after", 1'b0, RST_PC, NOP_INST, 1'b1); tick();

    // Randomized traffic
    ifu_pc = 32'h8000_0000;
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24100006_if_id.md
# ysyx_24100006_if_id

Fetch-to-decode pipeline buffer: the transmitting end of the handshake that feeds the decode stage. Accepts instruction/PC pairs from the IFU over a valid/ready handshake, holds them stable, and presents them to decode as `instruction`, `pc_D` and `id_out_valid`, honouring `id_out_ready`. It also discards wrong-path instructions on a control-flow redirect. It sits between the IFU and the IDU.

## Interface
Parameters:
- `RESET_INST`, 32'h0000_0013: instruction value presented after reset and after flush (addi x0,x0,0).
- `RESET_PC`, 32'h0000_0000: `pc_D` value after reset.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `if_valid`  in  1  IFU has a fetched instruction.
- `if_ready`  out  1  buffer can accept from IFU.
- `if_instruction`  in  32  fetched instruction.
- `if_pc`  in  32  PC of fetched instruction.
- `flush`  in  1  redirect from a later stage; kill all buffered entries.
- `id_out_valid`  out  1  entry presented to decode is valid.
- `id_out_ready`  in  1  decode accepts; already includes decode's stall.
- `instruction`  out  32  instruction to decode.
- `pc_D`  out  32  PC to decode.

## Operation
- IFU accept: `if_valid & if_ready`. Decode transfer: `id_out_valid & id_out_ready`.
- Storage: main slot, which drives the outputs, plus an optional skid slot (see Configuration).
- Data registers load only when written. Valid bits carry all control.
- Slot update with skid, in priority order:
  - `reset` or `flush`: both valids cleared; `instruction` ← `RESET_INST`. A same-cycle accept is dropped. `pc_D` holds its value (reset: `RESET_PC`).
  - Main empty + accept: main ← input.
  - Main full, transfer, skid full: main ← skid; skid cleared. `if_ready` is 0, so no accept can occur.
  - Main full, transfer, accept: main ← input.
  - Main full, no transfer, accept: skid ← input.
  - Main full, transfer, no accept: main cleared.
- `if_ready` = ~skid_valid & ~reset (registered source, no combinational path from `id_out_ready`).
- While `id_out_valid=1` and `id_out_ready=0`, `instruction`/`pc_D` must not change.
- Order is strictly FIFO; no duplication or loss except by flush.

## Timing
- Latency: accept in cycle N → `id_out_valid=1` with that data in N+1.
- Throughput: 1 instruction/cycle sustained while `id_out_ready=1`.
- Backpressure: `if_ready` deasserts the cycle after the skid slot fills. It reasserts the cycle after the skid slot drains.
- Flush: outputs invalid in cycle after `flush`. An accept in the cycle after flush is taken normally.
- Reset values: `id_out_valid=0`, `if_ready=0` during reset (1 in the first cycle after), `instruction=RESET_INST`, `pc_D=RESET_PC`.
- Reset mid-stall: all entries discarded; no transfer completes in the reset cycle.

## Configuration
- `YSYX_24100006_IFID_SKID_EN` defined: two-slot skid buffer as above. All outputs are registered.
- Undefined: main slot only. `if_ready = (~id_out_valid | id_out_ready) & ~reset`, a combinational pass-through of ready. Same latency, throughput, flush and reset behaviour. There is no skid slot.

## Structure
- Shared package `ysyx_24100006_pkg`: XLEN=32 constant and the NOP encoding 32'h0000_0013, used as the `RESET_INST` default.
- One natural sub-module: `ysyx_24100006_pipe_slot`, a valid + pc + instruction register with load/clear inputs. Instantiated once or twice, depending on the macro.

## Test plan
- Reset, then stream pc 0x8000_0000…0x8000_0010 with `id_out_ready=1` → `pc_D` follows one cycle behind; 5 transfers in 5 cycles; `if_ready` stays 1.
- With skid enabled: hold `id_out_ready=0` while streaming pc 0x100, 0x104, 0x108.
  - 0x100 held on the outputs; 0x104 goes to skid; `if_ready` falls.
  - 0x108 stays stalled at the IFU.
  - Release → 0x100, 0x104, 0x108 delivered in order, none lost.
- Stall with both slots full, then assert `flush` → next cycle `id_out_valid=0`, `instruction=0x0000_0013`. The 0x10C fetch offered in the flush cycle is never delivered.
- Simultaneous transfer + accept with main full (skid empty) → main updates to the new pc the next cycle; the skid slot stays empty.
- Assert `reset` mid-stall with entries buffered → `id_out_valid=0` and `if_ready=0` during reset. After reset: `if_ready=1` and `pc_D=RESET_PC`.
- Random `if_valid`/`id_out_ready`/`flush` for 10k cycles against a scoreboard → in-order, exactly-once delivery of unflushed instructions. Outputs stay stable under stall in both macro builds.
